alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single 16-bit ALU between two requesters: port 0 = execute stage, port 1 = address/aux unit.
//  Per-port valid/ready request channel with round-robin arbitration and a bounded lock for multi-op
//  sequences (e.g. ADD then ADC).
//  Drives the ALU operand/func inputs from the winner and registers its y/yhigh/flags into a
//  per-port response slot.
//  Sits between the decode/issue logic and the combinational ALU.
// PARAMETERS
//  N         16   datapath width; must match the ALU's N
//  LOCK_MAX  15   max consecutive cycles a lock may be held without an owner transfer (1..255)
// PORTS
//  clk                  input   1    clock, all state on rising edge
//  reset                input   1    synchronous, active-high
//  req_valid_0/1        input   1    request present on port i
//  req_ready_0/1        output  1    port i granted this cycle (combinational)
//  req_func_0/1         input   4    ALU func code
//  req_a_0/1, req_ahigh_0/1, req_b_0/1   input  N   ALU operands
//  req_ci_0/1, req_use32_0/1             input  1   carry-in, 32-bit mode
//  req_lock_0/1         input   1    hold grant for this port after this transfer
//  rsp_valid_0/1        output  1    response slot i full
//  rsp_ready_0/1        input   1    port i consumes its response
//  rsp_y_0/1, rsp_yhigh_0/1          output N   registered ALU results
//  rsp_flags_0/1        output  4    {co, zero, overflow, negative}, registered
//  alu_a, alu_ahigh, alu_b           output N   to ALU
//  alu_func (4), alu_ci (1), alu_use32 (1)     output   to ALU
//  alu_y, alu_yhigh     input   N    from ALU (combinational)
//  alu_co, alu_zero, alu_overflow, alu_negative   input 1   from ALU
//  lock_active          output  1    lock currently held
// BEHAVIOUR
//  - Reset: rsp_valid_* = 0, rsp_y_*/rsp_yhigh_*/rsp_flags_* = 0, lock_active = 0, lock counter = 0,
//    last_grant = 1 (port 0 wins first tie).
//  - Eligibility: elig_i = req_valid_i && (!rsp_valid_i || rsp_ready_i). A full, unconsumed slot blocks
//    port i.
//  - Grant (combinational):
//    - If locked, only the owner may be granted.
//    - Else if exactly one port is eligible, grant it.
//    - Else if both are eligible, grant the port != last_grant.
//    - At most one req_ready_* is high in any cycle.
//  - Transfer on req_valid_i && req_ready_i. ALU inputs = winner's operands in the same cycle.
//    With no grant, all alu_* outputs = 0.
//  - Latency 1: the transfer cycle's ALU outputs are captured at the clock edge; rsp_valid_i = 1 the
//    next cycle. Results hold until consumed.
//  - Slot i: a transfer sets rsp_valid_i and overwrites the data. A consume without a transfer clears
//    rsp_valid_i (data held). Transfer + consume in the same cycle leaves it set with the new data,
//    i.e. full throughput of 1 op/cycle per port.
//  - last_grant <= i on every transfer; it is not updated on idle cycles.
//  - Lock state machine, states UNLOCKED / LOCKED(owner):
//    - UNLOCKED -> LOCKED(i) on a transfer with req_lock_i = 1; counter cleared.
//    - LOCKED(i):
//      - owner transfer with req_lock_i = 1: stay, counter <= 0.
//      - owner transfer with req_lock_i = 0: -> UNLOCKED.
//      - no owner transfer: counter + 1; when counter == LOCKED_MAX-1 on a non-transfer cycle,
//        -> UNLOCKED next cycle (forced release).
//  - lock_active = (state == LOCKED). The owner blocked by its own full slot still counts toward the
//    timeout.
//  - Reset mid-sequence drops the lock and all pending responses; in-flight results are discarded.
//  - Flags are passed through unmodified; the arbiter does no arithmetic.
// TESTING
//  1. Port 0 alone, func=0000 a=0x0003 b=0x0004 -> req_ready_0=1 same cycle; next cycle rsp_valid_0=1,
//     rsp_y_0=0x0007, flags=0000.
//  2. Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 from reset; no cycle with both
//     ready high.
//  3. Port 0 ADD lock=1 then ADC lock=0 while port 1 valid -> port 1 stalled exactly until the ADC
//     transfer, granted the following cycle.
//  4. Port 1 locks then idles, LOCK_MAX=15 -> lock_active drops after 15 cycles; port 0 granted the
//     next cycle.
//  5. rsp_ready_0=0 with rsp_valid_0=1 and req_valid_0=1 -> req_ready_0=0, port 1 still served;
//     raising rsp_ready_0 allows transfer + consume in the same cycle.
//  6. Assert reset while locked with both slots full -> next cycle rsp_valid_*=0, lock_active=0,
//     port 0 wins the tie.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// The slave modport is the arbiter's view; master is the issue logic plus ALU side.
interface alu_arbiter_if #(
    parameter int N = 16
);
    logic         req_valid_0, req_valid_1;
    logic         req_ready_0, req_ready_1;
    logic [3:0]   req_func_0, req_func_1;
    logic [N-1:0] req_a_0, req_a_1;
    logic [N-1:0] req_ahigh_0, req_ahigh_1;
    logic [N-1:0] req_b_0, req_b_1;
    logic         req_ci_0, req_ci_1;
    logic         req_use32_0, req_use32_1;
    logic         req_lock_0, req_lock_1;

    logic         rsp_valid_0, rsp_valid_1;
    logic         rsp_ready_0, rsp_ready_1;
    logic [N-1:0] rsp_y_0, rsp_y_1;
    logic [N-1:0] rsp_yhigh_0, rsp_yhigh_1;
    logic [3:0]   rsp_flags_0, rsp_flags_1;

    logic [N-1:0] alu_a, alu_ahigh, alu_b;
    logic [3:0]   alu_func;
    logic         alu_ci, alu_use32;
    logic [N-1:0] alu_y, alu_yhigh;
    logic         alu_co, alu_zero, alu_overflow, alu_negative;

    logic         lock_active;

    modport slave (
        input  req_valid_0, req_valid_1, req_func_0, req_func_1,
               req_a_0, req_a_1, req_ahigh_0, req_ahigh_1, req_b_0, req_b_1,
               req_ci_0, req_ci_1, req_use32_0, req_use32_1, req_lock_0, req_lock_1,
               rsp_ready_0, rsp_ready_1,
               alu_y, alu_yhigh, alu_co, alu_zero, alu_overflow, alu_negative,
        output req_ready_0, req_ready_1,
               rsp_valid_0, rsp_valid_1, rsp_y_0, rsp_y_1, rsp_yhigh_0, rsp_yhigh_1,
               rsp_flags_0, rsp_flags_1,
               alu_a, alu_ahigh, alu_b, alu_func, alu_ci, alu_use32,
               lock_active
    );

    modport master (
        output req_valid_0, req_valid_1, req_func_0, req_func_1,
               req_a_0, req_a_1, req_ahigh_0, req_ahigh_1, req_b_0, req_b_1,
               req_ci_0, req_ci_1, req_use32_0, req_use32_1, req_lock_0, req_lock_1,
               rsp_ready_0, rsp_ready_1,
               alu_y, alu_yhigh, alu_co, alu_zero, alu_overflow, alu_negative,
        input  req_ready_0, req_ready_1,
               rsp_valid_0, rsp_valid_1, rsp_y_0, rsp_y_1, rsp_yhigh_0, rsp_yhigh_1,
               rsp_flags_0, rsp_flags_1,
               alu_a, alu_ahigh, alu_b, alu_func, alu_ci, alu_use32,
               lock_active
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU, with a
// bounded multi-op lock and a registered one-deep response slot per port.
module alu_arbiter #(
    parameter int N        = 16,
    parameter int LOCK_MAX = 15
) (
    input logic           clk,
    input logic           reset,
    alu_arbiter_if.slave  bus
);
    typedef enum logic { UNLOCKED, LOCKED } lock_state_t;

    localparam logic [7:0] LOCK_CNT_LAST = 8'(LOCK_MAX - 1);

    lock_state_t  state, state_nxt;
    logic         owner, owner_nxt;
    logic [7:0]   lock_cnt, lock_cnt_nxt;
    logic         last_grant;

    logic         elig0, elig1, gnt0, gnt1;
    logic         xfer_any, xfer_port, xfer_lock;

    logic         vld0_p1, vld1_p1;
    logic [N-1:0] y0_p1, y1_p1, yh0_p1, yh1_p1;
    logic [3:0]   fl0_p1, fl1_p1;

    // A full slot that is not being drained this cycle blocks its port.
    assign elig0 = bus.req_valid_0 && (!vld0_p1 || bus.rsp_ready_0);
    assign elig1 = bus.req_valid_1 && (!vld1_p1 || bus.rsp_ready_1);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == LOCKED) begin
            gnt0 = !owner && elig0;
            gnt1 =  owner && elig1;
        end else if (elig0 && elig1) begin
            gnt0 =  last_grant;
            gnt1 = !last_grant;
        end else begin
            gnt0 = elig0;
            gnt1 = elig1;
        end
    end

    assign bus.req_ready_0 = gnt0;
    assign bus.req_ready_1 = gnt1;
    assign xfer_any        = gnt0 || gnt1;
    assign xfer_port       = gnt1;
    assign xfer_lock       = gnt1 ? bus.req_lock_1 : bus.req_lock_0;
    assign bus.lock_active = (state == LOCKED);

    always_comb begin
        bus.alu_a     = '0;
        bus.alu_ahigh = '0;
        bus.alu_b     = '0;
        bus.alu_func  = '0;
        bus.alu_ci    = 1'b0;
        bus.alu_use32 = 1'b0;
        if (gnt0) begin
            bus.alu_a     = bus.req_a_0;
            bus.alu_ahigh = bus.req_ahigh_0;
            bus.alu_b     = bus.req_b_0;
            bus.alu_func  = bus.req_func_0;
            bus.alu_ci    = bus.req_ci_0;
            bus.alu_use32 = bus.req_use32_0;
        end else if (gnt1) begin
            bus.alu_a     = bus.req_a_1;
            bus.alu_ahigh = bus.req_ahigh_1;
            bus.alu_b     = bus.req_b_1;
            bus.alu_func  = bus.req_func_1;
            bus.alu_ci    = bus.req_ci_1;
            bus.alu_use32 = bus.req_use32_1;
        end
    end

    // Lock FSM: cycles without an owner transfer count toward forced release.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        lock_cnt_nxt = lock_cnt;
        case (state)
            UNLOCKED: begin
                if (xfer_any && xfer_lock) begin
                    state_nxt    = LOCKED;
                    owner_nxt    = xfer_port;
                    lock_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (xfer_any && (xfer_port == owner)) begin
                    lock_cnt_nxt = '0;
                    if (!xfer_lock) state_nxt = UNLOCKED;
                end else if (lock_cnt == LOCK_CNT_LAST) begin
                    state_nxt    = UNLOCKED;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = UNLOCKED;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= UNLOCKED;
            owner      <= 1'b0;
            lock_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (xfer_any) last_grant <= xfer_port;
        end
    end

    // Response stage: capture the ALU result of the transfer cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld0_p1 <= 1'b0;
            vld1_p1 <= 1'b0;
            y0_p1   <= '0;
            y1_p1   <= '0;
            yh0_p1  <= '0;
            yh1_p1  <= '0;
            fl0_p1  <= '0;
            fl1_p1  <= '0;
        end else begin
            if (gnt0) begin
                vld0_p1 <= 1'b1;
                y0_p1   <= bus.alu_y;
                yh0_p1  <= bus.alu_yhigh;
                fl0_p1  <= {bus.alu_co, bus.alu_zero, bus.alu_overflow, bus.alu_negative};
            end else if (bus.rsp_ready_0) begin
                vld0_p1 <= 1'b0;
            end
            if (gnt1) begin
                vld1_p1 <= 1'b1;
                y1_p1   <= bus.alu_y;
                yh1_p1  <= bus.alu_yhigh;
                fl1_p1  <= {bus.alu_co, bus.alu_zero, bus.alu_overflow, bus.alu_negative};
            end else if (bus.rsp_ready_1) begin
                vld1_p1 <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid_0 = vld0_p1;
    assign bus.rsp_valid_1 = vld1_p1;
    assign bus.rsp_y_0     = y0_p1;
    assign bus.rsp_y_1     = y1_p1;
    assign bus.rsp_yhigh_0 = yh0_p1;
    assign bus.rsp_yhigh_1 = yh1_p1;
    assign bus.rsp_flags_0 = fl0_p1;
    assign bus.rsp_flags_1 = fl1_p1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small add/adc ALU model on the ALU side.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    alu_arbiter_if #(.N(16)) bus();

    alu_arbiter #(.N(16), .LOCK_MAX(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ALU model: func[0] selects add-with-carry, otherwise plain add.
    logic [16:0] sum;
    assign sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'd0, bus.alu_func[0] & bus.alu_ci};
    assign bus.alu_y        = sum[15:0];
    assign bus.alu_yhigh    = bus.alu_ahigh;
    assign bus.alu_co       = sum[16];
    assign bus.alu_zero     = (sum[15:0] == 16'd0);
    assign bus.alu_negative = sum[15];
    assign bus.alu_overflow = (bus.alu_a[15] == bus.alu_b[15]) && (sum[15] != bus.alu_a[15]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic v, input logic [3:0] f, input logic [15:0] a,
                            input logic [15:0] b, input logic ci, input logic lk);
        bus.req_valid_0 = v; bus.req_func_0 = f; bus.req_a_0 = a; bus.req_b_0 = b;
        bus.req_ci_0 = ci; bus.req_lock_0 = lk; bus.req_ahigh_0 = 16'h00A0;
        bus.req_use32_0 = 1'b0;
    endtask

    task automatic set_req1(input logic v, input logic [3:0] f, input logic [15:0] a,
                            input logic [15:0] b, input logic ci, input logic lk);
        bus.req_valid_1 = v; bus.req_func_1 = f; bus.req_a_1 = a; bus.req_b_1 = b;
        bus.req_ci_1 = ci; bus.req_lock_1 = lk; bus.req_ahigh_1 = 16'h00B1;
        bus.req_use32_1 = 1'b0;
    endtask

    initial begin
        set_req0(0, 4'h0, 16'h0, 16'h0, 0, 0);
        set_req1(0, 4'h0, 16'h0, 16'h0, 0, 0);
        bus.rsp_ready_0 = 1'b0;
        bus.rsp_ready_1 = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid_0", bus.rsp_valid_0, 0);
        chk("rst_rsp_valid_1", bus.rsp_valid_1, 0);
        chk("rst_rsp_y_0", bus.rsp_y_0, 0);
        chk("rst_rsp_flags_1", bus.rsp_flags_1, 0);
        chk("rst_lock_active", bus.lock_active, 0);
        chk("idle_alu_a", bus.alu_a, 0);

        // Single request on port 0
        set_req0(1, 4'h0, 16'h0003, 16'h0004, 0, 0);
        #1;
        chk("t1_ready_0", bus.req_ready_0, 1);
        chk("t1_ready_1", bus.req_ready_1, 0);
        chk("t1_alu_b", bus.alu_b, 16'h0004);
        tick();
        bus.req_valid_0 = 1'b0;
        chk("t1_rsp_valid_0", bus.rsp_valid_0, 1);
        chk("t1_rsp_y_0", bus.rsp_y_0, 16'h0007);
        chk("t1_rsp_yhigh_0", bus.rsp_yhigh_0, 16'h00A0);
        chk("t1_rsp_flags_0", bus.rsp_flags_0, 4'b0000);
        #1;
        chk("t1_nogrant_alu_a", bus.alu_a, 0);
        bus.rsp_ready_0 = 1'b1;
        tick();
        chk("t1_consumed", bus.rsp_valid_0, 0);
        chk("t1_data_held", bus.rsp_y_0, 16'h0007);

        // Round robin from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.rsp_ready_0 = 1'b1;
        bus.rsp_ready_1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req0(1, 4'h0, 16'(k + 1), 16'h0010, 0, 0);
            set_req1(1, 4'h0, 16'h0200, 16'(k), 0, 0);
            #1;
            chk("t2_ready_0", bus.req_ready_0, (k % 2 == 0) ? 1 : 0);
            chk("t2_ready_1", bus.req_ready_1, (k % 2 == 0) ? 0 : 1);
            chk("t2_not_both", bus.req_ready_0 & bus.req_ready_1, 0);
            tick();
            if (k % 2 == 0) chk("t2_rsp_y_0", bus.rsp_y_0, 16'(k + 1 + 16'h10));
            else            chk("t2_rsp_y_1", bus.rsp_y_1, 16'(16'h200 + k));
        end

        // Locked ADD / ADC on port 0 with port 1 waiting
        set_req0(1, 4'h0, 16'hFFFF, 16'h0001, 0, 1);
        set_req1(1, 4'h0, 16'h0010, 16'h0020, 0, 0);
        #1;
        chk("t3_add_ready_0", bus.req_ready_0, 1);
        chk("t3_add_ready_1", bus.req_ready_1, 0);
        tick();
        chk("t3_lock_active", bus.lock_active, 1);
        chk("t3_add_y", bus.rsp_y_0, 16'h0000);
        chk("t3_add_flags", bus.rsp_flags_0, 4'b1100);
        bus.req_valid_0 = 1'b0;
        #1;
        chk("t3_gap_ready_1", bus.req_ready_1, 0);
        tick();
        set_req0(1, 4'h1, 16'h0001, 16'h0002, 1, 0);
        #1;
        chk("t3_adc_ready_0", bus.req_ready_0, 1);
        chk("t3_adc_ready_1", bus.req_ready_1, 0);
        tick();
        bus.req_valid_0 = 1'b0;
        chk("t3_unlocked", bus.lock_active, 0);
        chk("t3_adc_y", bus.rsp_y_0, 16'h0004);
        #1;
        chk("t3_p1_ready", bus.req_ready_1, 1);
        tick();
        chk("t3_p1_y", bus.rsp_y_1, 16'h0030);

        // Port 1 locks then idles; forced release after 15 cycles
        set_req1(1, 4'h0, 16'h0005, 16'h0005, 0, 1);
        #1;
        chk("t4_lock_ready_1", bus.req_ready_1, 1);
        tick();
        set_req1(0, 4'h0, 16'h0, 16'h0, 0, 0);
        set_req0(1, 4'h0, 16'h000A, 16'h000B, 0, 0);
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("t4_held", bus.lock_active, 1);
            chk("t4_p0_blocked", bus.req_ready_0, 0);
            tick();
        end
        #1;
        chk("t4_released", bus.lock_active, 0);
        chk("t4_p0_ready", bus.req_ready_0, 1);
        tick();
        chk("t4_p0_y", bus.rsp_y_0, 16'h0015);

        // Backpressure on port 0
        bus.rsp_ready_0 = 1'b0;
        set_req0(1, 4'h0, 16'h0100, 16'h0001, 0, 0);
        set_req1(1, 4'h0, 16'h7FFF, 16'h0001, 0, 0);
        #1;
        chk("t5_ready_0_blocked", bus.req_ready_0, 0);
        chk("t5_ready_1", bus.req_ready_1, 1);
        tick();
        chk("t5_p1_y", bus.rsp_y_1, 16'h8000);
        chk("t5_p1_flags", bus.rsp_flags_1, 4'b0011);
        chk("t5_p0_still_full", bus.rsp_valid_0, 1);
        chk("t5_p0_y_held", bus.rsp_y_0, 16'h0015);
        #1;
        chk("t5_ready_0_still_blocked", bus.req_ready_0, 0);
        bus.rsp_ready_0 = 1'b1;
        #1;
        chk("t5_ready_0_released", bus.req_ready_0, 1);
        chk("t5_ready_1_lost_tie", bus.req_ready_1, 0);
        tick();
        chk("t5_p0_valid", bus.rsp_valid_0, 1);
        chk("t5_p0_new_y", bus.rsp_y_0, 16'h0101);

        // Reset while locked with both slots full
        bus.rsp_ready_0 = 1'b0;
        bus.rsp_ready_1 = 1'b0;
        set_req0(0, 4'h0, 16'h0, 16'h0, 0, 0);
        set_req1(1, 4'h0, 16'h0042, 16'h0000, 0, 1);
        #1;
        chk("t6_ready_1", bus.req_ready_1, 1);
        tick();
        chk("t6_locked", bus.lock_active, 1);
        chk("t6_full_0", bus.rsp_valid_0, 1);
        chk("t6_full_1", bus.rsp_valid_1, 1);
        reset = 1'b1;
        set_req0(1, 4'h0, 16'h0001, 16'h0001, 0, 0);
        set_req1(1, 4'h0, 16'h0002, 16'h0002, 0, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_rsp_valid_0", bus.rsp_valid_0, 0);
        chk("t6_rsp_valid_1", bus.rsp_valid_1, 0);
        chk("t6_lock_dropped", bus.lock_active, 0);
        chk("t6_rsp_y_1", bus.rsp_y_1, 0);
        chk("t6_tie_ready_0", bus.req_ready_0, 1);
        chk("t6_tie_ready_1", bus.req_ready_1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
